rom_arbiter: RTL and testbench
==============================

// Module: rom_arbiter
// PURPOSE
//   Shares the single-port instruction ROM between two requesters: m0 = core instruction fetch,
//   m1 = data-bus load from the ROM region (constants/literal pools, debug reads). Drives the ROM
//   chip-enable and word address, registers the returned word, and raises a hold to the core.
//   Arbitration is fixed priority to m0, with an anti-starvation override that grants m1 after
//   MAX_WAIT consecutive denied cycles. Sits between the core/bus and the ROM in the SoC top.
// PARAMETERS
//   MAX_WAIT  4   consecutive denied m1 cycles before m1 is forced to win (1..15)
//   CNT_W     4   width of the starvation counter; must hold MAX_WAIT
// PORTS
//   clk          in   1              system clock
//   rst          in   1              asynchronous reset, active-low (`RstEnable = 1'b0)
//   m0_req_i     in   1              fetch request, held until granted
//   m0_addr_i    in   `InstAddrBus   fetch byte address
//   m0_gnt_o     out  1              m0 granted this cycle (combinational)
//   m0_rvalid_o  out  1              m0 read data valid (registered)
//   m0_rdata_o   out  `InstBus       m0 read data
//   m1_req_i     in   1              load request, held until granted
//   m1_addr_i    in   `InstAddrBus   load byte address
//   m1_gnt_o     out  1              m1 granted this cycle (combinational)
//   m1_rvalid_o  out  1              m1 read data valid (registered)
//   m1_rdata_o   out  `InstBus       m1 read data
//   hold_o       out  1              m0 requesting but not granted -> stall fetch pipeline
//   rom_ce_o     out  1              ROM chip enable (`ChipEnable when any grant)
//   rom_addr_o   out  `InstAddrBus   ROM byte address (granted requester's address, else 0)
//   rom_data_i   in   `InstBus       ROM combinational read data
// BEHAVIOUR
//   - Reset (rst=0, async): all outputs 0 / `ZeroInst; state PRI_M0; wait_cnt=0.
//   - FSM, 2 states: PRI_M0 (m0 wins ties), PRI_M1 (m1 wins ties).
//     PRI_M0 -> PRI_M1 when m1_req_i & !m1_gnt_o & wait_cnt==MAX_WAIT-1.
//     PRI_M1 -> PRI_M0 on the cycle m1 is granted, or when m1_req_i drops.
//   - Grant (same cycle): at most one of m0_gnt_o/m1_gnt_o high. Lone requester always granted.
//     Both requesting: winner per state. No request: rom_ce_o=`ChipDisable, rom_addr_o=0.
//   - wait_cnt: +1 each cycle m1_req_i & !m1_gnt_o (saturate at MAX_WAIT); cleared on m1 grant
//     or m1_req_i low.
//   - Latency: grant in cycle N; rdata captured from rom_data_i at edge end of N; rvalid_o=1 and
//     rdata_o valid in cycle N+1 for exactly one cycle, for the granted port only.
//     Ungranted port's rvalid_o=0 and rdata_o holds its previous value.
//   - Back-to-back: a port may be granted every cycle -> rvalid every cycle, 1-cycle pipeline.
//   - Address: passed through unmodified; word select and misalignment handling are the ROM's
//     (bits [1:0] ignored downstream); arbiter does no range check.
//   - hold_o = m0_req_i & !m0_gnt_o (combinational); never high when m0_req_i low.
//   - Reset asserted mid-transfer: pending rvalid dropped, no data delivered; requesters re-issue.
//   - Requester dropping req before grant: legal; no state besides wait_cnt/FSM is affected.
// STRUCTURE
//   - Uses existing define.v macros (`InstAddrBus, `InstBus, `ChipEnable/`ChipDisable,
//     `ZeroInst, `RstEnable); add to define.v: `ArbPriM0 1'b0, `ArbPriM1 1'b1.
//   - Single module, no sub-modules; grant logic combinational, FSM/counter/data regs sequential.
//   - Top-level instantiates rom_arbiter ahead of rom; rom ce_i/inst_addr_i driven from rom_*_o.
// TESTING
//   1 Reset: rst=0 with both reqs high -> all outputs 0, rom_ce_o=0; release -> m0 granted first.
//   2 m0 only, addr 0x0,0x4,0x8 consecutive -> gnt each cycle, rvalid+rdata=mem[0],[1],[2] in N+1.
//   3 m1 only, addr 0x10 -> m1_gnt_o same cycle, m1_rvalid_o=1, m1_rdata_o=mem[4] next cycle;
//     hold_o stays 0.
//   4 Both req continuously, MAX_WAIT=4 -> m0 granted 4 cycles (hold_o=0), m1 granted 5th cycle
//     with hold_o=1 that cycle, then m0 resumes; pattern repeats.
//   5 m1 req for 3 cycles then drops -> wait_cnt clears, FSM stays PRI_M0, no m1 grant.
//   6 Assert rst the cycle after an m0 grant -> m0_rvalid_o never pulses for that access.

Source files
------------

// File: rtl/rom_arbiter_pkg.sv
// Shared types and constants for the instruction-ROM arbiter.
// Bus widths, chip-enable levels, reset level and arbitration priority codes.
// Imported by rom_arbiter; no logic lives here beyond a small address-select helper.
package rom_arbiter_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam logic     CHIP_ENABLE  = 1'b1;
    localparam logic     CHIP_DISABLE = 1'b0;
    localparam logic     RST_ENABLE   = 1'b0;
    localparam inst_t    ZERO_INST    = '0;

    // Priority state: which requester wins when both ask in the same cycle.
    localparam logic [0:0] ARB_PRI_M0 = 1'b0;
    localparam logic [0:0] ARB_PRI_M1 = 1'b1;

    // ROM address for the current grant; zero when nobody is granted.
    function automatic inst_addr_t sel_addr(input logic g0, input inst_addr_t a0,
                                            input logic g1, input inst_addr_t a1);
        inst_addr_t a;
        a = '0;
        if (g0) begin
            a = a0;
        end else if (g1) begin
            a = a1;
        end
        return a;
    endfunction

endpackage

// File: rtl/rom_arbiter.sv
// Shares the single-port instruction ROM between core fetch (m0) and data-bus loads (m1).
// Latency: grant same cycle, read data and rvalid one cycle later (1-cycle pipeline, back-to-back ok).
// Backpressure: losing requester holds its request; m0 loss raises hold, m1 forced after MAX_WAIT denials.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m0_req_i,
    input  inst_addr_t m0_addr_i,
    output logic       m0_gnt_o,
    output logic       m0_rvalid_o,
    output inst_t      m0_rdata_o,
    input  logic       m1_req_i,
    input  inst_addr_t m1_addr_i,
    output logic       m1_gnt_o,
    output logic       m1_rvalid_o,
    output inst_t      m1_rdata_o,
    output logic       hold_o,
    output logic       rom_ce_o,
    output inst_addr_t rom_addr_o,
    input  inst_t      rom_data_i
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] WAIT_SAT  = CNT_W'(MAX_WAIT);

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             m1_deny;
    logic             in_reset;

    assign in_reset = (rst == RST_ENABLE);

    // Grant decision: lone requester wins, ties go to the current priority holder; nothing during reset.
    always_comb begin
        m0_gnt_o = 1'b0;
        m1_gnt_o = 1'b0;
        if (!in_reset) begin
            if (m0_req_i && m1_req_i) begin
                m0_gnt_o = (state == ARB_PRI_M0);
                m1_gnt_o = (state == ARB_PRI_M1);
            end else begin
                m0_gnt_o = m0_req_i;
                m1_gnt_o = m1_req_i;
            end
        end
    end

    assign m1_deny    = m1_req_i & ~m1_gnt_o;
    assign hold_o     = ~in_reset & m0_req_i & ~m0_gnt_o;
    assign rom_ce_o   = (m0_gnt_o | m1_gnt_o) ? CHIP_ENABLE : CHIP_DISABLE;
    assign rom_addr_o = sel_addr(m0_gnt_o, m0_addr_i, m1_gnt_o, m1_addr_i);

    // Priority flips to m1 on the denial that exhausts its wait budget, back once m1 is served or gives up.
    always_comb begin
        state_nxt = state;
        if (state == ARB_PRI_M0) begin
            if (m1_deny && (wait_cnt == WAIT_LAST)) begin
                state_nxt = ARB_PRI_M1;
            end
        end else begin
            if (m1_gnt_o || !m1_req_i) begin
                state_nxt = ARB_PRI_M0;
            end
        end
    end

    // Priority state and m1 starvation counter (counts consecutive denied cycles, saturating).
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state    <= ARB_PRI_M0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (!m1_deny) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_SAT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Read-return stage: capture ROM word for whichever port was granted; the other port keeps its data.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            m0_rvalid_o <= 1'b0;
            m1_rvalid_o <= 1'b0;
            m0_rdata_o  <= ZERO_INST;
            m1_rdata_o  <= ZERO_INST;
        end else begin
            m0_rvalid_o <= m0_gnt_o;
            m1_rvalid_o <= m1_gnt_o;
            if (m0_gnt_o) begin
                m0_rdata_o <= rom_data_i;
            end
            if (m1_gnt_o) begin
                m1_rdata_o <= rom_data_i;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed vector table, reset corner sequences, random traffic vs reference model.
module tb_rom_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk;
    logic        rst;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic        hold;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;

    logic [31:0] mem [64];

    int tests;
    int fails;

    rom_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .m0_req_i    (m0_req),
        .m0_addr_i   (m0_addr),
        .m0_gnt_o    (m0_gnt),
        .m0_rvalid_o (m0_rvalid),
        .m0_rdata_o  (m0_rdata),
        .m1_req_i    (m1_req),
        .m1_addr_i   (m1_addr),
        .m1_gnt_o    (m1_gnt),
        .m1_rvalid_o (m1_rvalid),
        .m1_rdata_o  (m1_rdata),
        .hold_o      (hold),
        .rom_ce_o    (rom_ce),
        .rom_addr_o  (rom_addr),
        .rom_data_i  (rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ROM model: word-addressed, byte address bits [1:0] ignored.
    assign rom_data = mem[rom_addr[7:2]];

    typedef struct {
        bit          m0r;
        logic [31:0] a0;
        bit          m1r;
        logic [31:0] a1;
        bit          g0;
        bit          g1;
        bit          hd;
        bit          rv0;
        bit          rv1;
        int          i0;
        int          i1;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input int idx);
        return (idx < 0) ? 32'h0 : mem[idx];
    endfunction

    function automatic void add(input bit m0r, input logic [31:0] a0, input bit m1r,
                                input logic [31:0] a1, input bit g0, input bit g1, input bit hd,
                                input bit rv0, input bit rv1, input int i0, input int i1);
        vec_t v;
        v.m0r = m0r; v.a0 = a0; v.m1r = m1r; v.a1 = a1;
        v.g0 = g0; v.g1 = g1; v.hd = hd; v.rv0 = rv0; v.rv1 = rv1; v.i0 = i0; v.i1 = i1;
        vecs.push_back(v);
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; m0_addr = '0; m1_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        int   streak;
        bit   pg0, pg1;
        bit   e_rv0, e_rv1;
        logic [31:0] e_rd0, e_rd1;
        logic [31:0] e_addr;
        bit   w0, w1;

        tests = 0;
        fails = 0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = {16'hC0DE, 8'(i), 8'(i) ^ 8'h5A};
        end

        // Reset held with both requesters active: everything must stay quiet.
        rst = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h0; m1_addr = 32'h10;
        repeat (2) @(negedge clk);
        check("rst_m0_gnt", {31'b0, m0_gnt}, 32'h0);
        check("rst_m1_gnt", {31'b0, m1_gnt}, 32'h0);
        check("rst_hold", {31'b0, hold}, 32'h0);
        check("rst_ce", {31'b0, rom_ce}, 32'h0);
        check("rst_addr", rom_addr, 32'h0);
        check("rst_rv0", {31'b0, m0_rvalid}, 32'h0);
        check("rst_rv1", {31'b0, m1_rvalid}, 32'h0);
        check("rst_rd0", m0_rdata, 32'h0);
        check("rst_rd1", m1_rdata, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rel_m0_first", {30'b0, m0_gnt, m1_gnt}, 32'h2);
        check("rel_hold", {31'b0, hold}, 32'h0);

        // Directed vectors (MAX_WAIT = 4); rv/rd columns describe this cycle's outputs.
        add(1, 32'h00, 0, 32'h00, 1, 0, 0, 0, 0, -1, -1);
        add(1, 32'h04, 0, 32'h00, 1, 0, 0, 1, 0,  0, -1);
        add(1, 32'h08, 0, 32'h00, 1, 0, 0, 1, 0,  1, -1);
        add(0, 32'h00, 0, 32'h00, 0, 0, 0, 1, 0,  2, -1);
        add(0, 32'h00, 1, 32'h10, 0, 1, 0, 0, 0,  2, -1);
        add(0, 32'h00, 0, 32'h00, 0, 0, 0, 0, 1,  2,  4);
        add(1, 32'h20, 1, 32'h30, 1, 0, 0, 0, 0,  2,  4);
        add(1, 32'h20, 1, 32'h30, 1, 0, 0, 1, 0,  8,  4);
        add(1, 32'h20, 1, 32'h30, 1, 0, 0, 1, 0,  8,  4);
        add(1, 32'h20, 1, 32'h30, 1, 0, 0, 1, 0,  8,  4);
        add(1, 32'h20, 1, 32'h30, 0, 1, 1, 1, 0,  8,  4);
        add(1, 32'h20, 1, 32'h30, 1, 0, 0, 0, 1,  8, 12);
        add(1, 32'h20, 1, 32'h30, 1, 0, 0, 1, 0,  8, 12);
        add(1, 32'h20, 1, 32'h30, 1, 0, 0, 1, 0,  8, 12);
        add(1, 32'h20, 1, 32'h30, 1, 0, 0, 1, 0,  8, 12);
        add(1, 32'h20, 1, 32'h30, 0, 1, 1, 1, 0,  8, 12);
        add(0, 32'h00, 0, 32'h00, 0, 0, 0, 0, 1,  8, 12);
        add(1, 32'h24, 1, 32'h34, 1, 0, 0, 0, 0,  8, 12);
        add(1, 32'h24, 1, 32'h34, 1, 0, 0, 1, 0,  9, 12);
        add(1, 32'h24, 1, 32'h34, 1, 0, 0, 1, 0,  9, 12);
        add(1, 32'h24, 0, 32'h00, 1, 0, 0, 1, 0,  9, 12);
        add(1, 32'h24, 1, 32'h34, 1, 0, 0, 1, 0,  9, 12);
        add(1, 32'h24, 1, 32'h34, 1, 0, 0, 1, 0,  9, 12);
        add(0, 32'h00, 0, 32'h00, 0, 0, 0, 1, 0,  9, 12);
        add(0, 32'h00, 0, 32'h00, 0, 0, 0, 0, 0,  9, 12);

        do_reset();
        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk);
            #1;
            m0_req = vecs[k].m0r; m0_addr = vecs[k].a0;
            m1_req = vecs[k].m1r; m1_addr = vecs[k].a1;
            @(negedge clk);
            e_addr = vecs[k].g0 ? vecs[k].a0 : (vecs[k].g1 ? vecs[k].a1 : 32'h0);
            check($sformatf("vec%0d_g0", k), {31'b0, m0_gnt}, {31'b0, vecs[k].g0});
            check($sformatf("vec%0d_g1", k), {31'b0, m1_gnt}, {31'b0, vecs[k].g1});
            check($sformatf("vec%0d_hold", k), {31'b0, hold}, {31'b0, vecs[k].hd});
            check($sformatf("vec%0d_ce", k), {31'b0, rom_ce}, {31'b0, vecs[k].g0 | vecs[k].g1});
            check($sformatf("vec%0d_addr", k), rom_addr, e_addr);
            check($sformatf("vec%0d_rv0", k), {31'b0, m0_rvalid}, {31'b0, vecs[k].rv0});
            check($sformatf("vec%0d_rv1", k), {31'b0, m1_rvalid}, {31'b0, vecs[k].rv1});
            check($sformatf("vec%0d_rd0", k), m0_rdata, word(vecs[k].i0));
            check($sformatf("vec%0d_rd1", k), m1_rdata, word(vecs[k].i1));
        end

        // Reset arriving before the granted access returns: its data must never appear.
        do_reset();
        @(posedge clk);
        #1 m0_req = 1'b1; m0_addr = 32'h04;
        @(negedge clk);
        check("abort_gnt", {31'b0, m0_gnt}, 32'h1);
        rst = 1'b0;
        @(posedge clk);
        #1 m0_req = 1'b0;
        @(negedge clk);
        check("abort_rv0_in_rst", {31'b0, m0_rvalid}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("abort_rv0_after_%0d", c), {31'b0, m0_rvalid}, 32'h0);
            check($sformatf("abort_rd0_after_%0d", c), m0_rdata, 32'h0);
            @(posedge clk);
        end

        // Random traffic against the reference rules.
        do_reset();
        streak = 0; pg0 = 1'b1; pg1 = 1'b1;
        e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd0 = 32'h0; e_rd1 = 32'h0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            if (pg0 || !m0_req) begin
                m0_req = ($urandom_range(0, 99) < 70);
                m0_addr = 32'($urandom_range(0, 255));
            end else if ($urandom_range(0, 99) < 5) begin
                m0_req = 1'b0;
            end
            if (pg1 || !m1_req) begin
                m1_req = ($urandom_range(0, 99) < 50);
                m1_addr = 32'($urandom_range(0, 255));
            end else if ($urandom_range(0, 99) < 5) begin
                m1_req = 1'b0;
            end
            // m1 takes a tie only once it has been passed over MAX_WAIT cycles in a row.
            w1 = m1_req && (!m0_req || streak >= MAX_WAIT);
            w0 = m0_req && !w1;
            e_addr = w0 ? m0_addr : (w1 ? m1_addr : 32'h0);
            @(negedge clk);
            check("rnd_g0", {31'b0, m0_gnt}, {31'b0, w0});
            check("rnd_g1", {31'b0, m1_gnt}, {31'b0, w1});
            check("rnd_hold", {31'b0, hold}, {31'b0, m0_req && !w0});
            check("rnd_ce", {31'b0, rom_ce}, {31'b0, w0 || w1});
            check("rnd_addr", rom_addr, e_addr);
            check("rnd_rv0", {31'b0, m0_rvalid}, {31'b0, e_rv0});
            check("rnd_rv1", {31'b0, m1_rvalid}, {31'b0, e_rv1});
            check("rnd_rd0", m0_rdata, e_rd0);
            check("rnd_rd1", m1_rdata, e_rd1);
            e_rv0 = w0;
            e_rv1 = w1;
            if (w0) e_rd0 = mem[m0_addr[7:2]];
            if (w1) e_rd1 = mem[m1_addr[7:2]];
            streak = (m1_req && !w1) ? streak + 1 : 0;
            pg0 = w0;
            pg1 = w1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
